// File: rtl/imem_loader_if.sv
// Bundled handshake and memory-side signals between the program source and the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              load_start;
    logic [9:0]        load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              cpu_run;
    logic              busy;
    logic              load_err;
    logic [9:0]        words_loaded;
    logic [15:0]       checksum;

    modport master (
        output load_start, load_len, byte_in, byte_valid, pc_addr,
        input  byte_ready, mem_addr, mem_wdata, mem_we, cpu_run, busy,
               load_err, words_loaded, checksum
    );

    modport slave (
        input  load_start, load_len, byte_in, byte_valid, pc_addr,
        output byte_ready, mem_addr, mem_wdata, mem_we, cpu_run, busy,
               load_err, words_loaded, checksum
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory as big-endian 16-bit words,
// then hands the memory address port to the PC and releases the CPU.
//
// state | meaning
// IDLE  | no load since reset; CPU held
// HI    | waiting for high byte of the next word
// LO    | waiting for low byte of the next word
// WR    | one-cycle write of the assembled word at wp
// DONE  | image complete; CPU runs, PC drives the address
module imem_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HI, LO, WR, DONE} state_t;

    localparam logic [9:0] LEN_MAX = 10'(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_wp;
    logic [9:0]        r_len;
    logic [9:0]        r_words;
    logic [15:0]       r_sum;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_busy;
    logic              r_err;

    logic w_len_ok;
    logic w_can_start;
    logic w_last;

    assign w_len_ok    = (bus.load_len != 10'd0) && (bus.load_len <= LEN_MAX);
    assign w_can_start = (r_state == IDLE) || (r_state == DONE);
    assign w_last      = (r_words + 10'd1) == r_len;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (bus.load_start && w_len_ok) w_state_next = HI;
            HI:         if (bus.byte_valid) w_state_next = LO;
            LO:         if (bus.byte_valid) w_state_next = WR;
            WR:         w_state_next = w_last ? DONE : HI;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_sum   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Registered strobes track the state being entered so they align with it.
            r_we    <= (w_state_next == WR);
            r_busy  <= (w_state_next == HI) || (w_state_next == LO) || (w_state_next == WR);

            if (w_can_start && bus.load_start) begin
                if (w_len_ok) begin
                    r_len   <= bus.load_len;
                    r_wp    <= '0;
                    r_words <= '0;
                    r_sum   <= '0;
                    r_err   <= 1'b0;
                end else begin
                    r_err   <= 1'b1;
                end
            end

            if (r_state == HI && bus.byte_valid) r_wdata[15:8] <= bus.byte_in;
            if (r_state == LO && bus.byte_valid) r_wdata[7:0]  <= bus.byte_in;

            if (r_state == WR) begin
                r_sum   <= r_sum + r_wdata;
                r_words <= r_words + 10'd1;
                if (!w_last) r_wp <= r_wp + 1'b1;
            end
        end
    end

    assign bus.byte_ready   = (r_state == HI) || (r_state == LO);
    assign bus.cpu_run      = (r_state == DONE);
    assign bus.mem_addr     = (r_state == DONE) ? bus.pc_addr : r_wp;
    assign bus.mem_wdata    = r_wdata;
    assign bus.mem_we       = r_we;
    assign bus.busy         = r_busy;
    assign bus.load_err     = r_err;
    assign bus.words_loaded = r_words;
    assign bus.checksum     = r_sum;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: length-legality table, write scoreboard,
// and directed sequences for stalls, mid-load reset, reload and full-depth load.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    imem_loader #(.ADDR_W(9), .DATA_W(16), .DEPTH(512)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [9:0]  len;
        logic        exp_err;
        logic        exp_busy;
        logic        exp_run;
        logic [15:0] word;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_e;
    vec_t vecs[5];
    int   checks   = 0;
    int   errors   = 0;
    int   consumed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write must match the next expected {addr, data} in order.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
            end
        end
    end

    // Handshakes sampled just before the rising edge, when everything is settled.
    always @(negedge clk) begin
        #4;
        if (rst && bus.byte_valid && bus.byte_ready) consumed++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst = 1'b0;
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start(input logic [9:0] len);
        bus.load_len   = len;
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [8:0] addr, input logic [15:0] w);
        send_byte(w[15:8]);
        sb.push_back('{addr: addr, data: w});
        send_byte(w[7:0]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.cpu_run && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(bus.cpu_run), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_mem_we",   32'(bus.mem_we), 32'd0);
        check("rst_wdata",    32'(bus.mem_wdata), 32'd0);
        check("rst_ready",    32'(bus.byte_ready), 32'd0);
        check("rst_run",      32'(bus.cpu_run), 32'd0);
        check("rst_busy",     32'(bus.busy), 32'd0);
        check("rst_err",      32'(bus.load_err), 32'd0);
        check("rst_words",    32'(bus.words_loaded), 32'd0);
        check("rst_checksum", 32'(bus.checksum), 32'd0);
    endtask

    initial begin
        int c0;
        vecs[0] = '{len: 10'd0,    exp_err: 1'b1, exp_busy: 1'b0, exp_run: 1'b0, word: 16'h0000};
        vecs[1] = '{len: 10'd513,  exp_err: 1'b1, exp_busy: 1'b0, exp_run: 1'b0, word: 16'h0000};
        vecs[2] = '{len: 10'd1023, exp_err: 1'b1, exp_busy: 1'b0, exp_run: 1'b0, word: 16'h0000};
        vecs[3] = '{len: 10'd1,    exp_err: 1'b0, exp_busy: 1'b1, exp_run: 1'b0, word: 16'h0102};
        vecs[4] = '{len: 10'd600,  exp_err: 1'b1, exp_busy: 1'b0, exp_run: 1'b1, word: 16'h0000};

        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.pc_addr    = 9'h1AA;

        do_reset();
        check_reset_vals();

        // Length legality from IDLE, a legal single-word load, then illegal from DONE.
        for (int i = 0; i < 5; i++) begin
            start(vecs[i].len);
            check("tbl_err",   32'(bus.load_err), 32'(vecs[i].exp_err));
            check("tbl_busy",  32'(bus.busy), 32'(vecs[i].exp_busy));
            check("tbl_ready", 32'(bus.byte_ready), 32'(vecs[i].exp_busy));
            check("tbl_run",   32'(bus.cpu_run), 32'(vecs[i].exp_run));
            if (!vecs[i].exp_err) begin
                send_word(9'd0, vecs[i].word);
                wait_done();
                check("tbl_checksum", 32'(bus.checksum), 32'(vecs[i].word));
                check("tbl_words",    32'(bus.words_loaded), 32'd1);
            end
        end

        // Two-word load with a continuous byte stream, then PC takes the address.
        do_reset();
        start(10'd2);
        send_word(9'd0, 16'h1234);
        send_word(9'd1, 16'hABCD);
        wait_done();
        check("two_checksum", 32'(bus.checksum), 32'hBE01);
        check("two_words",    32'(bus.words_loaded), 32'd2);
        check("two_run",      32'(bus.cpu_run), 32'd1);
        bus.pc_addr = 9'd5;
        @(negedge clk);
        check("two_pc_mux", 32'(bus.mem_addr), 32'd5);
        bus.pc_addr = 9'h1AA;

        // Reset while waiting for the low byte of word 3.
        do_reset();
        start(10'd5);
        send_word(9'd0, 16'h1000);
        send_word(9'd1, 16'h2001);
        send_word(9'd2, 16'h3002);
        send_byte(8'h40);
        check("mid_in_lo", 32'(bus.byte_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_vals();
        start(10'd1);
        send_word(9'd0, 16'h7777);
        wait_done();
        check("mid_reload_words", 32'(bus.words_loaded), 32'd1);

        // Reload from DONE with a stalled source (valid 1-0-0-1), then held valid.
        start(10'd1);
        check("reload_run_drop", 32'(bus.cpu_run), 32'd0);
        check("reload_checksum", 32'(bus.checksum), 32'd0);
        check("reload_words",    32'(bus.words_loaded), 32'd0);
        c0 = consumed;
        bus.byte_in = 8'h5A; bus.byte_valid = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.byte_in = 8'hC3; bus.byte_valid = 1'b1;
        sb.push_back('{addr: 9'd0, data: 16'h5AC3});
        @(negedge clk);
        check("wr_we",    32'(bus.mem_we), 32'd1);
        check("wr_ready", 32'(bus.byte_ready), 32'd0);
        check("wr_addr0", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        check("stall_run",      32'(bus.cpu_run), 32'd1);
        check("stall_checksum", 32'(bus.checksum), 32'h5AC3);
        @(negedge clk);
        check("stall_consumed", 32'(consumed - c0), 32'd2);
        bus.byte_valid = 1'b0;

        // Full-depth load, word i = i.
        start(10'd512);
        for (int i = 0; i < 512; i++) send_word(9'(i), 16'(i));
        wait_done();
        check("full_words",    32'(bus.words_loaded), 32'd512);
        check("full_checksum", 32'(bus.checksum), 32'hFF00);
        check("full_run",      32'(bus.cpu_run), 32'd1);

        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
